// File: rtl/gray2rgb_mapper.sv
// ----------------------------------------------------------------------------
// gray2rgb_mapper
//
// Purpose:
//   Display-side conversion of an 8-bit grayscale pixel stream into 12-bit per
//   channel RGB. Four display modes are supported: replicated grey, heat map,
//   binary threshold and inverted grey. The mode and the threshold are latched
//   on the rising edge of the frame-valid signal. A frame therefore always uses
//   one mode from start to end.
//
// Ports:
//   iCLK       in   1       pixel clock, rising edge
//   iReset     in   1       asynchronous active-high reset
//   iGray      in   8       grayscale pixel
//   iDval      in   1       iGray valid this cycle
//   iFval      in   1       frame valid (high during a frame)
//   iMode      in   2       requested mode: 00 grey, 01 heat, 10 threshold,
//                           11 inverted grey
//   iThresh    in   8       requested threshold for mode 10
//   oRed       out  12      red channel
//   oGreen     out  12      green channel
//   oBlue      out  12      blue channel
//   oDval      out  1       channel outputs valid (iDval delayed by 2 cycles)
//   oFrameCnt  out  FCNT_W  completed frames since reset (wraps)
//   oMode      out  2       mode currently in effect
// ----------------------------------------------------------------------------
module gray2rgb_mapper #(
   parameter logic [7:0] THRESH_RST = 8'd128,
   parameter int         FCNT_W     = 16
) (
   input  logic              iCLK,
   input  logic              iReset,
   input  logic [7:0]        iGray,
   input  logic              iDval,
   input  logic              iFval,
   input  logic [1:0]        iMode,
   input  logic [7:0]        iThresh,
   output logic [11:0]       oRed,
   output logic [11:0]       oGreen,
   output logic [11:0]       oBlue,
   output logic              oDval,
   output logic [FCNT_W-1:0] oFrameCnt,
   output logic [1:0]        oMode
);

   localparam logic [1:0] MODE_GREY   = 2'b00;
   localparam logic [1:0] MODE_HEAT   = 2'b01;
   localparam logic [1:0] MODE_THRESH = 2'b10;
   localparam logic [1:0] MODE_INV    = 2'b11;

   // Widen an 8-bit channel to 12 bits by repeating the top nibble, so that
   // 8'h00 maps to 12'h000 and 8'hFF maps to 12'hFFF.
   function automatic logic [11:0] expand12(input logic [7:0] v);
      return {v, v[7:4]};
   endfunction

   // ------------------------------------------------------------------
   // Frame edge detection
   // ------------------------------------------------------------------
   logic r_fval_d;
   logic w_rise;
   logic w_fall;

   assign w_rise = iFval & ~r_fval_d;
   assign w_fall = ~iFval & r_fval_d;

   // Register frame-valid for edge detection.
   always_ff @(posedge iCLK or posedge iReset) begin
      if (iReset) begin
         r_fval_d <= 1'b0;
      end else begin
         r_fval_d <= iFval;
      end
   end

   // ------------------------------------------------------------------
   // Per-frame mode / threshold latch
   // ------------------------------------------------------------------
   logic [1:0] r_mode;
   logic [7:0] r_thresh;
   logic [1:0] w_sel_mode;
   logic [7:0] w_sel_thresh;

   // Latch the requested mode and threshold only at frame start.
   always_ff @(posedge iCLK or posedge iReset) begin
      if (iReset) begin
         r_mode   <= MODE_GREY;
         r_thresh <= THRESH_RST;
      end else if (w_rise) begin
         r_mode   <= iMode;
         r_thresh <= iThresh;
      end else begin
         r_mode   <= r_mode;
         r_thresh <= r_thresh;
      end
   end

   // A pixel arriving in the rise cycle itself must already see the new
   // frame's settings, before the latch above has updated.
   always_comb begin
      w_sel_mode   = r_mode;
      w_sel_thresh = r_thresh;
      if (w_rise) begin
         w_sel_mode   = iMode;
         w_sel_thresh = iThresh;
      end else begin
         w_sel_mode   = r_mode;
         w_sel_thresh = r_thresh;
      end
   end

   // ------------------------------------------------------------------
   // Completed-frame counter
   // ------------------------------------------------------------------
   logic [FCNT_W-1:0] r_frame_cnt;

   // Count falling edges of frame valid. The counter wraps naturally.
   always_ff @(posedge iCLK or posedge iReset) begin
      if (iReset) begin
         r_frame_cnt <= {FCNT_W{1'b0}};
      end else if (w_fall) begin
         r_frame_cnt <= r_frame_cnt + {{(FCNT_W-1){1'b0}}, 1'b1};
      end else begin
         r_frame_cnt <= r_frame_cnt;
      end
   end

   // ------------------------------------------------------------------
   // Stage 1: capture pixel and the settings that apply to it
   // ------------------------------------------------------------------
   logic [7:0] r_s1_gray;
   logic [1:0] r_s1_mode;
   logic [7:0] r_s1_thresh;
   logic       r_s1_dval;

   // The first pipeline stage samples every cycle. Its dval bit qualifies
   // the data it holds.
   always_ff @(posedge iCLK or posedge iReset) begin
      if (iReset) begin
         r_s1_gray   <= 8'h00;
         r_s1_mode   <= MODE_GREY;
         r_s1_thresh <= 8'h00;
         r_s1_dval   <= 1'b0;
      end else begin
         r_s1_gray   <= iGray;
         r_s1_mode   <= w_sel_mode;
         r_s1_thresh <= w_sel_thresh;
         r_s1_dval   <= iDval;
      end
   end

   // ------------------------------------------------------------------
   // Channel arithmetic
   // ------------------------------------------------------------------
   logic [1:0] w_seg;
   logic [7:0] w_frac;
   logic [7:0] w_r8;
   logic [7:0] w_g8;
   logic [7:0] w_b8;

   // For the heat map, the top two bits select one of four colour ramps.
   // The low six bits, scaled by 4, give the position along that ramp.
   assign w_seg  = r_s1_gray[7:6];
   assign w_frac = {r_s1_gray[5:0], 2'b00};

   // Compute the 8-bit channel values for the captured pixel.
   always_comb begin
      w_r8 = 8'h00;
      w_g8 = 8'h00;
      w_b8 = 8'h00;
      case (r_s1_mode)
         MODE_GREY: begin
            w_r8 = r_s1_gray;
            w_g8 = r_s1_gray;
            w_b8 = r_s1_gray;
         end
         MODE_INV: begin
            w_r8 = ~r_s1_gray;
            w_g8 = ~r_s1_gray;
            w_b8 = ~r_s1_gray;
         end
         MODE_THRESH: begin
            if (r_s1_gray >= r_s1_thresh) begin
               w_r8 = 8'hFF;
               w_g8 = 8'hFF;
               w_b8 = 8'hFF;
            end else begin
               w_r8 = 8'h00;
               w_g8 = 8'h00;
               w_b8 = 8'h00;
            end
         end
         MODE_HEAT: begin
            // The ramps run blue -> cyan -> green/yellow -> red.
            case (w_seg)
               2'd0: begin
                  w_r8 = 8'h00;
                  w_g8 = w_frac;
                  w_b8 = 8'hFF;
               end
               2'd1: begin
                  w_r8 = 8'h00;
                  w_g8 = 8'hFF;
                  w_b8 = 8'hFF - w_frac;
               end
               2'd2: begin
                  w_r8 = w_frac;
                  w_g8 = 8'hFF;
                  w_b8 = 8'h00;
               end
               2'd3: begin
                  w_r8 = 8'hFF;
                  w_g8 = 8'hFF - w_frac;
                  w_b8 = 8'h00;
               end
               default: begin
                  w_r8 = 8'h00;
                  w_g8 = 8'h00;
                  w_b8 = 8'h00;
               end
            endcase
         end
         default: begin
            w_r8 = 8'h00;
            w_g8 = 8'h00;
            w_b8 = 8'h00;
         end
      endcase
   end

   // ------------------------------------------------------------------
   // Stage 2: output registers
   // ------------------------------------------------------------------
   logic [11:0] r_red;
   logic [11:0] r_green;
   logic [11:0] r_blue;
   logic        r_dval;

   // Output valid follows stage-1 valid unconditionally.
   always_ff @(posedge iCLK or posedge iReset) begin
      if (iReset) begin
         r_dval <= 1'b0;
      end else begin
         r_dval <= r_s1_dval;
      end
   end

   // Channel data loads only for a valid pixel. During bubbles the last
   // pixel's colour is held.
   always_ff @(posedge iCLK or posedge iReset) begin
      if (iReset) begin
         r_red   <= 12'h000;
         r_green <= 12'h000;
         r_blue  <= 12'h000;
      end else if (r_s1_dval) begin
         r_red   <= expand12(w_r8);
         r_green <= expand12(w_g8);
         r_blue  <= expand12(w_b8);
      end else begin
         r_red   <= r_red;
         r_green <= r_green;
         r_blue  <= r_blue;
      end
   end

   assign oRed      = r_red;
   assign oGreen    = r_green;
   assign oBlue     = r_blue;
   assign oDval     = r_dval;
   assign oFrameCnt = r_frame_cnt;
   assign oMode     = r_mode;

endmodule
